// File: rtl/mode_record.sv
// rtl/mode_record.sv - records free-mode notes into the packed song buffer (option: RECORD_SKIP_LEADING_REST_EN)
module mode_record #(
    parameter int SECOND    = 10000000,
    parameter int SONG_TIME = 56
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rec_btn,
    input  logic                   clear,
    input  logic [3:0]             note_in,
    input  logic [1:0]             octave_in,
    output logic [SONG_TIME*4-1:0] song_packed,
    output logic [SONG_TIME*4-1:0] time_packed,
    output logic [SONG_TIME*2-1:0] octave_packed,
    output logic [5:0]             count,
    output logic                   recording,
    output logic                   full,
    output logic                   overflow
);

    localparam int CW = (SECOND > 2) ? $clog2(SECOND) : 1;
    localparam int IW = (SONG_TIME > 2) ? $clog2(SONG_TIME) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(SECOND - 1);
    localparam logic [5:0]    FULL_AT  = 6'(SONG_TIME - 1);
    localparam logic [3:0]    NOTE_END = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REC,
        ST_FINISH
    } state_t;

    state_t state_q, state_d;

    logic [3:0]    song_mem [SONG_TIME];
    logic [3:0]    time_mem [SONG_TIME];
    logic [1:0]    oct_mem  [SONG_TIME];

    logic          rec_prev;
    logic [3:0]    seg_note;
    logic [1:0]    seg_oct;
    logic [3:0]    units;
    logic [CW-1:0] cyc;

    logic          rec_rise;
    logic          seg_diff;
    logic          cyc_wrap;
    logic [IW-1:0] wr_idx;
    logic          skip_commit;

    logic          do_start;
    logic          do_clear;
    logic          do_commit;
    logic          do_term;
    logic          seg_load;
    logic          seg_split;
    logic          inc_units;
    logic          inc_cyc;
    logic [3:0]    c_units;

    assign rec_rise  = rec_btn & ~rec_prev;
    assign seg_diff  = (note_in != seg_note) || (octave_in != seg_oct);
    assign cyc_wrap  = (cyc == CYC_LAST);
    assign wr_idx    = count[IW-1:0];
    assign full      = (count == FULL_AT);
    assign recording = (state_q == ST_REC);

`ifdef RECORD_SKIP_LEADING_REST_EN
    // A rest before the first sounded note is not worth a slot.
    assign skip_commit = (count == 6'd0) && (seg_note == 4'd0);
`else
    assign skip_commit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle datapath strobes; stop edge outranks change and split.
    always_comb begin
        state_d   = state_q;
        do_start  = 1'b0;
        do_clear  = 1'b0;
        do_commit = 1'b0;
        do_term   = 1'b0;
        seg_load  = 1'b0;
        seg_split = 1'b0;
        inc_units = 1'b0;
        inc_cyc   = 1'b0;
        c_units   = units;
        case (state_q)
            ST_IDLE: begin
                if (rec_rise) begin
                    do_start = 1'b1;
                    state_d  = ST_REC;
                end else if (clear) begin
                    do_clear = 1'b1;
                end
            end
            ST_REC: begin
                if (rec_rise) begin
                    do_commit = 1'b1;
                    state_d   = ST_FINISH;
                end else if (seg_diff) begin
                    do_commit = 1'b1;
                    seg_load  = 1'b1;
                end else if (cyc_wrap) begin
                    if (units == 4'd15) begin
                        do_commit = 1'b1;
                        c_units   = 4'd15;
                        seg_split = 1'b1;
                    end else begin
                        inc_units = 1'b1;
                    end
                end else begin
                    inc_cyc = 1'b1;
                end
            end
            ST_FINISH: begin
                do_term = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Segment tracker, entry counter and song buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rec_prev <= 1'b0;
            seg_note <= 4'd0;
            seg_oct  <= 2'd0;
            units    <= 4'd0;
            cyc      <= '0;
            count    <= 6'd0;
            overflow <= 1'b0;
            for (int i = 0; i < SONG_TIME; i++) begin
                song_mem[i] <= (i == 0) ? NOTE_END : 4'd0;
                time_mem[i] <= 4'd0;
                oct_mem[i]  <= 2'd0;
            end
        end else begin
            rec_prev <= rec_btn;

            if (do_start || seg_load) begin
                seg_note <= note_in;
                seg_oct  <= octave_in;
                units    <= 4'd1;
                cyc      <= '0;
            end
            if (seg_split) begin
                units <= 4'd1;
                cyc   <= '0;
            end
            if (inc_units) begin
                units <= units + 4'd1;
                cyc   <= '0;
            end
            if (inc_cyc) begin
                cyc <= cyc + 1'b1;
            end

            if (do_start) begin
                count    <= 6'd0;
                overflow <= 1'b0;
            end

            // The last slot is reserved for the terminator, so a full buffer drops the entry.
            if (do_commit && !skip_commit) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    song_mem[wr_idx] <= seg_note;
                    time_mem[wr_idx] <= c_units;
                    oct_mem[wr_idx]  <= seg_oct;
                    count            <= count + 6'd1;
                end
            end

            if (do_term) begin
                song_mem[wr_idx] <= NOTE_END;
                time_mem[wr_idx] <= 4'd0;
                oct_mem[wr_idx]  <= 2'd0;
            end

            if (do_clear) begin
                count    <= 6'd0;
                overflow <= 1'b0;
                for (int i = 0; i < SONG_TIME; i++) begin
                    song_mem[i] <= (i == 0) ? NOTE_END : 4'd0;
                    time_mem[i] <= 4'd0;
                    oct_mem[i]  <= 2'd0;
                end
            end
        end
    end

    // Flatten the buffer into the packed song format.
    always_comb begin
        song_packed   = '0;
        time_packed   = '0;
        octave_packed = '0;
        for (int i = 0; i < SONG_TIME; i++) begin
            song_packed[4*i +: 4]   = song_mem[i];
            time_packed[4*i +: 4]   = time_mem[i];
            octave_packed[2*i +: 2] = oct_mem[i];
        end
    end

endmodule

// File: tb/tb_mode_record.sv
// tb/tb_mode_record.sv - randomized and directed checks of mode_record against a run-length song model
module tb_mode_record;

    localparam int S = 4;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           rec_btn = 1'b0;
    logic           clear = 1'b0;
    logic [3:0]     note_in = 4'd0;
    logic [1:0]     octave_in = 2'd0;
    logic [N*4-1:0] song_packed;
    logic [N*4-1:0] time_packed;
    logic [N*2-1:0] octave_packed;
    logic [5:0]     count;
    logic           recording;
    logic           full;
    logic           overflow;

    int checks = 0;
    int passed = 0;

    // Model state: the song buffer as plain arrays.
    int exp_note [N];
    int exp_time [N];
    int exp_oct  [N];
    int exp_count;
    int exp_ovf;
    logic [N*4-1:0] exp_song;
    logic [N*4-1:0] exp_timep;
    logic [N*2-1:0] exp_octp;

    // Segment schedule for a recording: note, octave, cycles held.
    int sn [16];
    int so [16];
    int sl [16];
    int nseg;

    mode_record #(.SECOND(S), .SONG_TIME(N)) dut (
        .clk(clk),
        .reset(reset),
        .rec_btn(rec_btn),
        .clear(clear),
        .note_in(note_in),
        .octave_in(octave_in),
        .song_packed(song_packed),
        .time_packed(time_packed),
        .octave_packed(octave_packed),
        .count(count),
        .recording(recording),
        .full(full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task model_init;
        for (int i = 0; i < N; i++) begin
            exp_note[i] = (i == 0) ? 15 : 0;
            exp_time[i] = 0;
            exp_oct[i]  = 0;
        end
        exp_count = 0;
        exp_ovf   = 0;
    endtask

    task model_commit(input int n, input int u, input int o);
`ifdef RECORD_SKIP_LEADING_REST_EN
        if (exp_count == 0 && n == 0) return;
`endif
        if (exp_count == N - 1) begin
            exp_ovf = 1;
        end else begin
            exp_note[exp_count] = n;
            exp_time[exp_count] = u;
            exp_oct[exp_count]  = o;
            exp_count++;
        end
    endtask

    // Each held segment becomes whole 15-unit chunks plus a rounded-up remainder.
    task model_record;
        int len;
        exp_count = 0;
        exp_ovf   = 0;
        for (int k = 0; k < nseg; k++) begin
            len = sl[k];
            while (len > 15 * S) begin
                model_commit(sn[k], 15, so[k]);
                len -= 15 * S;
            end
            model_commit(sn[k], (len + S - 1) / S, so[k]);
        end
        exp_note[exp_count] = 15;
        exp_time[exp_count] = 0;
        exp_oct[exp_count]  = 0;
    endtask

    task build_exp;
        for (int i = 0; i < N; i++) begin
            exp_song[4*i +: 4]  = exp_note[i][3:0];
            exp_timep[4*i +: 4] = exp_time[i][3:0];
            exp_octp[2*i +: 2]  = exp_oct[i][1:0];
        end
    endtask

    // Plays the schedule, starting from a negedge with rec_btn low, and ends after the terminator lands.
    task run_rec;
        for (int k = 0; k < nseg; k++) begin
            for (int c = 0; c < sl[k]; c++) begin
                note_in   = sn[k][3:0];
                octave_in = so[k][1:0];
                rec_btn   = (k == 0 && c == 0);
                @(negedge clk);
                if (k == 0 && c == 0) begin
                    checks++;
                    if (recording !== 1'b1) $display("FAIL rec_rise: recording=%b want 1", recording);
                    else passed++;
                end
            end
        end
        rec_btn = 1'b1;
        @(negedge clk);
        rec_btn = 1'b0;
        checks++;
        if (recording !== 1'b0) $display("FAIL rec_fall: recording=%b want 0", recording);
        else passed++;
        @(negedge clk);
        model_record();
        build_exp();
    endtask

    task test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_init();
        build_exp();
        checks++;
        if (song_packed[3:0] !== 4'hF) $display("FAIL reset_slot0: got %h want f", song_packed[3:0]);
        else passed++;
        checks++;
        if (song_packed !== exp_song) $display("FAIL reset_song: got %h want %h", song_packed, exp_song);
        else passed++;
        checks++;
        if (time_packed !== '0 || octave_packed !== '0) $display("FAIL reset_time_oct: got %h/%h want 0", time_packed, octave_packed);
        else passed++;
        checks++;
        if ({count, recording, full, overflow} !== 9'd0) $display("FAIL reset_flags: got %0d %b%b%b want 0 000", count, recording, full, overflow);
        else passed++;
    endtask

    task test_basic;
        nseg = 2;
        sn[0] = 1; so[0] = 0; sl[0] = 8;
        sn[1] = 3; so[1] = 0; sl[1] = 5;
        run_rec();
        checks++;
        if (count !== 6'd2) $display("FAIL basic_count: got %0d want 2", count);
        else passed++;
        checks++;
        if (song_packed[11:0] !== 12'hF31) $display("FAIL basic_notes: got %h want f31", song_packed[11:0]);
        else passed++;
        checks++;
        if (time_packed[7:0] !== 8'h22) $display("FAIL basic_times: got %h want 22", time_packed[7:0]);
        else passed++;
        checks++;
        if (song_packed !== exp_song || time_packed !== exp_timep) $display("FAIL basic_model: got %h/%h want %h/%h", song_packed, time_packed, exp_song, exp_timep);
        else passed++;
    endtask

    task test_long_split;
        nseg = 1;
        sn[0] = 5; so[0] = 2; sl[0] = 70;
        run_rec();
        checks++;
        if (song_packed[11:0] !== 12'hF55) $display("FAIL long_notes: got %h want f55", song_packed[11:0]);
        else passed++;
        checks++;
        if (time_packed[7:0] !== 8'h3F) $display("FAIL long_times: got %h want 3f", time_packed[7:0]);
        else passed++;
        checks++;
        if (octave_packed[5:0] !== 6'b001010) $display("FAIL long_oct: got %b want 001010", octave_packed[5:0]);
        else passed++;
    endtask

    task test_overflow;
        nseg = 9;
        for (int k = 0; k < 9; k++) begin
            sn[k] = (k % 7) + 1; so[k] = 1; sl[k] = 2;
        end
        run_rec();
        checks++;
        if (count !== 6'(N - 1)) $display("FAIL ovf_count: got %0d want %0d", count, N - 1);
        else passed++;
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1) $display("FAIL ovf_flags: full=%b overflow=%b want 1 1", full, overflow);
        else passed++;
        checks++;
        if (song_packed[N*4-1 -: 4] !== 4'hF) $display("FAIL ovf_term: got %h want f", song_packed[N*4-1 -: 4]);
        else passed++;
        checks++;
        if (song_packed !== exp_song || time_packed !== exp_timep) $display("FAIL ovf_model: got %h/%h want %h/%h", song_packed, time_packed, exp_song, exp_timep);
        else passed++;
    endtask

    task test_clear_idle;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        model_init();
        build_exp();
        checks++;
        if (song_packed !== exp_song || time_packed !== exp_timep || octave_packed !== exp_octp) $display("FAIL clear_buf: got %h/%h/%h want %h/%h/%h", song_packed, time_packed, octave_packed, exp_song, exp_timep, exp_octp);
        else passed++;
        checks++;
        if (count !== 6'd0 || overflow !== 1'b0) $display("FAIL clear_flags: count=%0d overflow=%b want 0 0", count, overflow);
        else passed++;
    endtask

    task test_leading_rest;
        nseg = 2;
        sn[0] = 0; so[0] = 0; sl[0] = 6;
        sn[1] = 2; so[1] = 0; sl[1] = 4;
        run_rec();
`ifdef RECORD_SKIP_LEADING_REST_EN
        checks++;
        if (count !== 6'd1 || song_packed[7:0] !== 8'hF2 || time_packed[3:0] !== 4'h1) $display("FAIL lead_rest: got %0d %h %h want 1 f2 1", count, song_packed[7:0], time_packed[3:0]);
        else passed++;
`else
        checks++;
        if (count !== 6'd2 || song_packed[11:0] !== 12'hF20 || time_packed[7:0] !== 8'h12) $display("FAIL lead_rest: got %0d %h %h want 2 f20 12", count, song_packed[11:0], time_packed[7:0]);
        else passed++;
`endif
        checks++;
        if (song_packed !== exp_song || time_packed !== exp_timep) $display("FAIL lead_model: got %h/%h want %h/%h", song_packed, time_packed, exp_song, exp_timep);
        else passed++;
    endtask

    task test_random;
        for (int r = 0; r < 8; r++) begin
            nseg = $urandom_range(1, 10);
            for (int k = 0; k < nseg; k++) begin
                do begin
                    sn[k] = $urandom_range(0, 7);
                    so[k] = $urandom_range(0, 3);
                end while (k > 0 && sn[k] == sn[k-1] && so[k] == so[k-1]);
                sl[k] = ($urandom_range(0, 4) == 0) ? $urandom_range(55, 70) : $urandom_range(1, 12);
            end
            run_rec();
            checks++;
            if (song_packed !== exp_song) $display("FAIL rand%0d_song: got %h want %h", r, song_packed, exp_song);
            else passed++;
            checks++;
            if (time_packed !== exp_timep) $display("FAIL rand%0d_time: got %h want %h", r, time_packed, exp_timep);
            else passed++;
            checks++;
            if (octave_packed !== exp_octp) $display("FAIL rand%0d_oct: got %h want %h", r, octave_packed, exp_octp);
            else passed++;
            checks++;
            if (count !== 6'(exp_count) || overflow !== exp_ovf[0]) $display("FAIL rand%0d_flags: got %0d %b want %0d %0d", r, count, overflow, exp_count, exp_ovf);
            else passed++;
        end
    endtask

    task test_rec_clear_and_reset;
        note_in = 4'd4; octave_in = 2'd1; rec_btn = 1'b1;
        @(negedge clk);
        rec_btn = 1'b0;
        repeat (3) @(negedge clk);
        note_in = 4'd6;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (count !== 6'd1 || recording !== 1'b1 || song_packed[3:0] !== 4'd4 || time_packed[3:0] !== 4'd1) $display("FAIL rec_clear: got %0d %b %h %h want 1 1 4 1", count, recording, song_packed[3:0], time_packed[3:0]);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_init();
        build_exp();
        checks++;
        if (song_packed !== exp_song || time_packed !== exp_timep || octave_packed !== exp_octp) $display("FAIL midrec_reset_buf: got %h/%h/%h want %h/%h/%h", song_packed, time_packed, octave_packed, exp_song, exp_timep, exp_octp);
        else passed++;
        checks++;
        if (count !== 6'd0 || recording !== 1'b0) $display("FAIL midrec_reset_flags: count=%0d recording=%b want 0 0", count, recording);
        else passed++;
    endtask

    initial begin
        model_init();
        test_reset();
        test_basic();
        test_long_split();
        test_overflow();
        test_clear_idle();
        test_leading_rest();
        test_random();
        test_rec_clear_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mode_record.md
# mode_record

Records notes played live in free mode into a fixed-length song buffer, producing the same packed note/duration/octave arrays that auto-play mode replays. It is the writer for the song format auto mode reads: 4-bit note codes (0 = rest, 4'hF = end-of-song), 4-bit durations in units of `SECOND` clock cycles, and 2-bit octaves. It sits beside the free-mode keyboard decoder and feeds the user-song slot of the song library.

## Interface
- `SECOND`, 10000000: clock cycles per duration unit.
- `SONG_TIME`, 56: buffer slots. Must be ≤ 64.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `rec_btn`  in  1  start/stop button; acts on its rising edge.
- `clear`  in  1  empties the buffer; honoured only in IDLE.
- `note_in`  in  4  current free-mode note (0 = rest, 1..7 = notes).
- `octave_in`  in  2  current free-mode octave.
- `song_packed`  out  SONG_TIME*4  slot i is at bits [4i+3:4i].
- `time_packed`  out  SONG_TIME*4  duration of slot i, at bits [4i+3:4i].
- `octave_packed`  out  SONG_TIME*2  octave of slot i, at bits [2i+1:2i].
- `count`  out  6  number of committed entries.
- `recording`  out  1  high in REC.
- `full`  out  1  high when `count == SONG_TIME-1`.
- `overflow`  out  1  sticky: a commit was dropped.

## Operation
- Rising edge on `rec_btn` means `rec_btn == 1` and the previous-cycle sample is 0. The previous-cycle sample is registered every cycle.
- States:
  - IDLE: edge → REC. In the same cycle set `count <= 0` and `overflow <= 0`, and open a segment from the current `note_in`/`octave_in` with `units = 1`, `cyc = 0`. Buffer contents are not cleared.
  - REC: see segment and stop rules below.
  - FINISH: write note 4'hF, time 0 and octave 0 to `slot[count]`. `count` does not change. Next state IDLE.
- Segment tracking in REC, evaluated every cycle:
  - If (`note_in`, `octave_in`) differs from the open segment: commit the segment, then open a new one from the inputs with `units = 1`, `cyc = 0`.
  - Otherwise, if `cyc == SECOND-1`: set `cyc <= 0`.
    - If `units == 15`: commit (note, 15) and reopen the same note with `units = 1`. Long notes split this way.
    - Otherwise `units <= units + 1`.
  - Otherwise `cyc <= cyc + 1`.
  - Result: a segment held L cycles records `min(15, ceil(L/SECOND))` units.
- Stop: a rising edge in REC commits the open segment, then moves to FINISH. The edge cycle does not count toward the segment duration. The stop edge takes priority over the change and split rules in that cycle.
- Commit: write (note, units, octave) to `slot[count]` and do `count <= count + 1`. If `full`, drop the commit and set `overflow`. Slot `SONG_TIME-1` is therefore always free for the terminator.
- Rests (note 0) are recorded as ordinary entries.
- `clear` in IDLE: slot 0 gets note 4'hF; all other fields go to 0. Set `count <= 0` and `overflow <= 0`. `clear` is ignored in REC and FINISH.
- Buffer outputs are live during REC. Consumers must read them only when `recording == 0`.

## Timing
- Reset values:
  - State IDLE.
  - `song_packed` has slot 0 = 4'hF and all other slots 0.
  - `time_packed` = 0 and `octave_packed` = 0.
  - `count` = 0, `recording` = 0, `full` = 0, `overflow` = 0.
  - Previous-cycle `rec_btn` sample = 0; `units` and `cyc` = 0.
- A reset while in REC or FINISH aborts the recording. The buffer returns to its reset contents.
- `recording` rises 1 cycle after the start edge.
- A commit is visible on outputs 1 cycle after the triggering cycle.
- Terminator is visible 2 cycles after the stop edge; `recording` falls 1 cycle after the stop edge.
- A rising edge seen in FINISH is ignored.

## Configuration
- `RECORD_SKIP_LEADING_REST_EN`:
  - Defined: while `count == 0`, a commit whose note is 0 is discarded. `count` is unchanged and `overflow` is not set, so recordings start at the first sounded note.
  - Undefined: leading rests are recorded like any other entry.

## Test plan
- Reset → `song_packed[3:0] = 4'hF`, `count = 0`, `recording = 0`, `overflow = 0`.
- `SECOND = 4`: start, `note_in = 1` for 8 REC cycles, `note_in = 3` for 5 cycles, stop → slot0 = (1, 2), slot1 = (3, 2), slot2 note = 4'hF, `count = 2`.
- `SECOND = 4`: note 5 at octave 2 held 70 cycles, then stop → slot0 = (5, 15, oct 2), slot1 = (5, 3, oct 2), slot2 = 4'hF.
- `SONG_TIME = 4`, `SECOND = 2`: 5 distinct notes of 2 cycles each, then stop → `count = 3`, `full = 1`, `overflow = 1`, slot3 note = 4'hF.
- Reset asserted mid-REC → buffer back to reset contents; pulse `clear` during REC → no effect.
- Macro defined: rest for 6 cycles, then note 2 for 4 cycles, stop → slot0 = (2, 1), `count = 1`. Undefined: slot0 = (0, 2), slot1 = (2, 1).
